// File: rtl/bht_local_hist_predictor_pkg.sv
// Shared types and helpers for the local-history branch predictor.
package bht_local_hist_predictor_pkg;

    localparam int unsigned BHT_HIST_MAX = 4;
    localparam int unsigned BHT_CTRS     = 16;
    localparam logic [1:0]  BHT_CTR_RESET = 2'b01;

    // Storage is sized for the largest supported history; unused upper hist bits stay zero.
    typedef struct packed {
        logic                           valid;
        logic [BHT_HIST_MAX-1:0]        hist;
        logic [BHT_CTRS-1:0][1:0]       ctr;
    } bht_entry_t;

    // 2-bit saturating counter step.
    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    // Untrained entry: invalid, empty history, all counters weakly not-taken.
    function automatic bht_entry_t bht_entry_reset();
        bht_entry_t e;
        e.valid = 1'b0;
        e.hist  = '0;
        e.ctr   = {BHT_CTRS{BHT_CTR_RESET}};
        return e;
    endfunction

endpackage

// File: rtl/bht_local_hist_predictor_entry.sv
// One predictor entry: local history plus its pattern counters.
module bht_local_hist_predictor_entry
    import bht_local_hist_predictor_pkg::*;
#(
    parameter int unsigned HIST = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic upd_en_i,
    input  logic upd_taken_i,
    output logic valid_c,
    output logic taken_c
);

    localparam logic [BHT_HIST_MAX-1:0] HIST_MASK = BHT_HIST_MAX'((1 << HIST) - 1);

    bht_entry_t entry_q, entry_d;

    // Next state: flush beats update; counter chosen by pre-update history.
    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = bht_entry_reset();
        end else if (upd_en_i) begin
            entry_d.ctr[entry_q.hist] = sat_ctr_next(entry_q.ctr[entry_q.hist], upd_taken_i);
            entry_d.hist  = ((entry_q.hist << 1) | BHT_HIST_MAX'(upd_taken_i)) & HIST_MASK;
            entry_d.valid = 1'b1;
        end
    end

    // Entry state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) entry_q <= bht_entry_reset();
        else         entry_q <= entry_d;
    end

    assign valid_c = entry_q.valid;
    assign taken_c = entry_q.valid & entry_q.ctr[entry_q.hist][1];

endmodule

// File: rtl/bht_local_hist_predictor.sv
// Per-slot local-history branch predictor: index decode and per-slot output mux.
module bht_local_hist_predictor
    import bht_local_hist_predictor_pkg::*;
#(
    parameter int unsigned VLEN            = 32,
    parameter int unsigned NR_ENTRIES      = 32,
    parameter int unsigned HIST            = 3,
    parameter int unsigned INSTR_PER_FETCH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_bp_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       upd_valid_i,
    input  logic [VLEN-1:0]            upd_pc_i,
    input  logic                       upd_taken_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o
);

    localparam int unsigned OFFSET    = $clog2(INSTR_PER_FETCH) + 1;
    localparam int unsigned ROWS      = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_BITS  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned SLOT_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;

    if ((NR_ENTRIES & (NR_ENTRIES - 1)) != 0) begin : g_chk_pow2
        $error("NR_ENTRIES must be a power of two");
    end
    if ((NR_ENTRIES % INSTR_PER_FETCH) != 0) begin : g_chk_div
        $error("NR_ENTRIES must be a multiple of INSTR_PER_FETCH");
    end
    if ((HIST < 1) || (HIST > BHT_HIST_MAX)) begin : g_chk_hist
        $error("HIST must be in 1..4");
    end

    logic [ROW_BITS-1:0]   vpc_row;
    logic [ROW_BITS-1:0]   upd_row;
    logic [SLOT_BITS-1:0]  upd_slot;
    logic                  upd_go;
    logic [NR_ENTRIES-1:0] ent_valid_c;
    logic [NR_ENTRIES-1:0] ent_taken_c;
    logic                  unused_pc_bits;

    assign vpc_row = vpc_i[OFFSET+ROW_BITS-1:OFFSET];
    assign upd_row = upd_pc_i[OFFSET+ROW_BITS-1:OFFSET];
    assign upd_go  = upd_valid_i & ~debug_mode_i;

    if (INSTR_PER_FETCH > 1) begin : g_slot
        assign upd_slot = upd_pc_i[OFFSET-1:1];
    end else begin : g_noslot
        assign upd_slot = '0;
    end

    // Tag-less indexing: remaining PC bits are deliberately ignored.
    assign unused_pc_bits = ^{vpc_i, upd_pc_i};

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar s = 0; s < INSTR_PER_FETCH; s++) begin : g_col
            logic upd_en;
            assign upd_en = upd_go && (upd_row == ROW_BITS'(r)) && (upd_slot == SLOT_BITS'(s));

            bht_local_hist_predictor_entry #(
                .HIST (HIST)
            ) u_entry (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .flush_i     (flush_bp_i),
                .upd_en_i    (upd_en),
                .upd_taken_i (upd_taken_i),
                .valid_c     (ent_valid_c[r*INSTR_PER_FETCH+s]),
                .taken_c     (ent_taken_c[r*INSTR_PER_FETCH+s])
            );
        end
    end

    // Report every slot of the looked-up row; no bypass from a same-cycle update.
    always_comb begin
        pred_valid_o = '0;
        pred_taken_o = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (vpc_row == ROW_BITS'(r)) begin
                for (int unsigned s = 0; s < INSTR_PER_FETCH; s++) begin
                    pred_valid_o[s] = ent_valid_c[r*INSTR_PER_FETCH+s];
                    pred_taken_o[s] = ent_taken_c[r*INSTR_PER_FETCH+s];
                end
            end
        end
    end

endmodule
